// File: rtl/logic_pipe.sv
// Pipelined bitwise logic unit: one of eight gate functions on WIDTH-bit operands,
// carried through STAGES registers with valid/ready flow control and a saturating transfer counter.
module logic_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       OP,
    input  logic             IN_VALID,
    output logic             IN_READY,
    output logic [WIDTH-1:0] X,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [CNT_W-1:0] COUNT
);

    logic [STAGES-1:0] vld;
    logic [WIDTH-1:0]  dat [STAGES];
    logic [STAGES-1:0] vld_in;
    logic [WIDTH-1:0]  dat_in [STAGES];
    logic [WIDTH-1:0]  func_c;
    logic              advance;
    logic [CNT_W-1:0]  count_q;

    // Gate function selected by OP, evaluated ahead of stage 1
    always_comb begin
        func_c = A;
        case (OP)
            3'b000:  func_c = ~A;
            3'b001:  func_c = A & B;
            3'b010:  func_c = A | B;
            3'b011:  func_c = A ^ B;
            3'b100:  func_c = ~(A & B);
            3'b101:  func_c = ~(A | B);
            3'b110:  func_c = ~(A ^ B);
            default: func_c = A;
        endcase
    end

    // Incoming valid/data for each stage: stage 0 from the input, others from their predecessor
    always_comb begin
        vld_in[0] = IN_VALID;
        dat_in[0] = func_c;
        for (int i = 1; i < STAGES; i++) begin
            vld_in[i] = vld[i-1];
            dat_in[i] = dat[i-1];
        end
    end

    // Whole pipe moves together; a full, unaccepted output stalls every stage
    assign advance  = ~vld[STAGES-1] | OUT_READY;
    assign IN_READY = advance;

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld     <= '0;
            count_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= '0;
            end
        end else begin
            if (advance) begin
                vld <= vld_in;
                // Data only loads behind a valid item, so X keeps the last result while idle
                for (int i = 0; i < STAGES; i++) begin
                    if (vld_in[i]) begin
                        dat[i] <= dat_in[i];
                    end
                end
            end
            if (vld[STAGES-1] && OUT_READY && (count_q != {CNT_W{1'b1}})) begin
                count_q <= count_q + CNT_W'(1);
            end
        end
    end

    assign X         = dat[STAGES-1];
    assign OUT_VALID = vld[STAGES-1];
    assign COUNT     = count_q;

endmodule
